// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - recovers a 4-digit BCD value from a multiplexed seven-segment bus
module seg7_scan_capture #(
    parameter int STABLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [3:0]  DIG,
    input  logic [6:0]  SEGS,
    output logic [15:0] VALUE,
    output logic        VALID,
    output logic        ERR
);

    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYC);

    logic [10:0]      samp_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             taken_q;
    logic             taken_next;
    logic [3:0]       got_q;
    logic [15:0]      shadow_q;

    logic [3:0]       samp_dig;
    logic [6:0]       samp_segs;
    logic             same;
    logic             accept;
    logic             seg_legal;
    logic [3:0]       seg_bcd;
    logic             dig_onehot;
    logic             acc_good;
    logic             acc_bad;
    logic [3:0]       got_merge;
    logic [15:0]      shadow_merge;
    logic             frame_done;

    assign samp_dig  = samp_q[10:7];
    assign samp_segs = samp_q[6:0];
    assign same      = ({DIG, SEGS} == samp_q);

    always_comb begin
        seg_legal = 1'b1;
        seg_bcd   = 4'd0;
        case (samp_segs)
            7'b1111110: seg_bcd = 4'd0;
            7'b0110000: seg_bcd = 4'd1;
            7'b1101101: seg_bcd = 4'd2;
            7'b1111001: seg_bcd = 4'd3;
            7'b0110011: seg_bcd = 4'd4;
            7'b1011011: seg_bcd = 4'd5;
            7'b1011111: seg_bcd = 4'd6;
            7'b1110000: seg_bcd = 4'd7;
            7'b1111111: seg_bcd = 4'd8;
            7'b1111011: seg_bcd = 4'd9;
            default:    seg_legal = 1'b0;
        endcase
    end

    always_comb begin
        dig_onehot = 1'b0;
        case (samp_dig)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: dig_onehot = 1'b1;
            default:                            dig_onehot = 1'b0;
        endcase
    end

    // One accept per dwell: counter must sit at STABLE and this dwell not yet used.
    assign accept   = EN && (cnt_q == STABLE) && !taken_q;
    assign acc_good = accept && dig_onehot && seg_legal;
    assign acc_bad  = accept && (samp_dig != 4'b0000) && !(dig_onehot && seg_legal);

    always_comb begin
        if (!EN) begin
            cnt_next = '0;
        end else if (same) begin
            cnt_next = (cnt_q == STABLE) ? cnt_q : cnt_q + 1'b1;
        end else begin
            cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        if (!EN || !same) begin
            taken_next = 1'b0;
        end else begin
            taken_next = taken_q | accept;
        end
    end

    // The strobe is one-hot when this is used, so it doubles as the digit mask.
    always_comb begin
        got_merge    = got_q | samp_dig;
        shadow_merge = shadow_q;
        for (int i = 0; i < 4; i++) begin
            if (samp_dig[i]) begin
                shadow_merge[i*4 +: 4] = seg_bcd;
            end
        end
    end

    assign frame_done = acc_good && (got_merge == 4'b1111);

    always_ff @(posedge CLK) begin
        if (RST) begin
            samp_q   <= '0;
            cnt_q    <= '0;
            taken_q  <= 1'b0;
            got_q    <= 4'b0000;
            shadow_q <= 16'h0000;
            VALUE    <= 16'h0000;
            VALID    <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            samp_q  <= {DIG, SEGS};
            cnt_q   <= cnt_next;
            taken_q <= taken_next;
            VALID   <= frame_done;
            ERR     <= acc_bad;
            if (!EN || acc_bad) begin
                got_q <= 4'b0000;
            end else if (acc_good) begin
                shadow_q <= shadow_merge;
                got_q    <= frame_done ? 4'b0000 : got_merge;
            end
            if (frame_done) begin
                VALUE <= shadow_merge;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - directed vector bench for seg7_scan_capture
module tb_seg7_scan_capture;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [3:0]  DIG;
    logic [6:0]  SEGS;
    logic [15:0] VALUE;
    logic        VALID;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                           S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                           S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111,
                           S9 = 7'b1111011, SBAD = 7'b0000001;

    typedef struct {
        logic        en;
        logic [3:0]  dig;
        logic [6:0]  segs;
        int          hold;
        int          exp_v;
        int          exp_e;
        logic [15:0] exp_value;
    } vec_t;

    vec_t vecs[$];

    seg7_scan_capture #(.STABLE_CYC(4), .CNT_W(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .DIG   (DIG),
        .SEGS  (SEGS),
        .VALUE (VALUE),
        .VALID (VALID),
        .ERR   (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic [3:0] dig, input logic [6:0] segs,
                       input int hold, input int exp_v, input int exp_e, input logic [15:0] val);
        vec_t v;
        v.en = en; v.dig = dig; v.segs = segs; v.hold = hold;
        v.exp_v = exp_v; v.exp_e = exp_e; v.exp_value = val;
        vecs.push_back(v);
    endtask

    // Drive a pattern for a number of cycles, returning pulse counts seen.
    task automatic drive(input logic en, input logic [3:0] dig, input logic [6:0] segs,
                         input int hold, output int vcnt, output int ecnt);
        vcnt = 0;
        ecnt = 0;
        @(negedge CLK);
        EN = en; DIG = dig; SEGS = segs;
        for (int c = 0; c < hold; c++) begin
            @(posedge CLK);
            #1;
            if (VALID) vcnt++;
            if (ERR) ecnt++;
        end
    endtask

    initial begin
        int vc, ec;
        RST = 1'b1; EN = 1'b0; DIG = 4'b0000; SEGS = 7'b0000000;

        // frame 3210, then a long dwell on one digit, then a mid-frame illegal pattern
        add(1, 4'b1000, S3,   6, 0, 0, 16'h0000);
        add(1, 4'b0100, S2,   6, 0, 0, 16'h0000);
        add(1, 4'b0010, S1,   6, 0, 0, 16'h0000);
        add(1, 4'b0001, S0,   6, 1, 0, 16'h3210);
        add(1, 4'b0001, S5,  20, 0, 0, 16'h3210);
        add(1, 4'b1000, S4,   6, 0, 0, 16'h3210);
        add(1, 4'b0010, SBAD, 5, 0, 1, 16'h3210);
        add(1, 4'b1000, S1,   6, 0, 0, 16'h3210);
        add(1, 4'b0100, S2,   6, 0, 0, 16'h3210);
        add(1, 4'b0010, S3,   6, 0, 0, 16'h3210);
        add(1, 4'b0001, S4,   6, 1, 0, 16'h1234);
        // two strobes clear the captured mask
        add(1, 4'b1000, S9,   6, 0, 0, 16'h1234);
        add(1, 4'b0110, S8,   5, 0, 1, 16'h1234);
        add(1, 4'b0100, S8,   6, 0, 0, 16'h1234);
        add(1, 4'b0010, S7,   6, 0, 0, 16'h1234);
        add(1, 4'b0001, S6,   6, 0, 0, 16'h1234);
        add(1, 4'b1000, S5,   6, 1, 0, 16'h5876);
        // short glitch and blanking are ignored
        add(1, 4'b0001, S4,   6, 0, 0, 16'h5876);
        add(1, 4'b0001, S8,   3, 0, 0, 16'h5876);
        add(1, 4'b0000, 7'b0, 6, 0, 0, 16'h5876);
        add(1, 4'b1000, S1,   6, 0, 0, 16'h5876);
        add(1, 4'b0100, S2,   6, 0, 0, 16'h5876);
        add(1, 4'b0010, S3,   6, 1, 0, 16'h1234);
        // disable after three digits, then a fresh frame
        add(1, 4'b1000, S9,   6, 0, 0, 16'h1234);
        add(1, 4'b0100, S8,   6, 0, 0, 16'h1234);
        add(1, 4'b0010, S7,   6, 0, 0, 16'h1234);
        add(0, 4'b0001, S6,   6, 0, 0, 16'h1234);
        add(1, 4'b0001, S6,   6, 0, 0, 16'h1234);
        add(1, 4'b0010, S7,   6, 0, 0, 16'h1234);
        add(1, 4'b0100, S8,   6, 0, 0, 16'h1234);
        add(1, 4'b1000, S9,   6, 1, 0, 16'h9876);

        repeat (3) @(posedge CLK);
        #1;
        chk("reset VALUE", 32'(VALUE), 32'h0);
        chk("reset VALID", 32'(VALID), 32'h0);
        chk("reset ERR",   32'(ERR),   32'h0);
        @(negedge CLK);
        RST = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].dig, vecs[i].segs, vecs[i].hold, vc, ec);
            chk($sformatf("step%0d valid_count", i), 32'(vc), 32'(vecs[i].exp_v));
            chk($sformatf("step%0d err_count", i),   32'(ec), 32'(vecs[i].exp_e));
            chk($sformatf("step%0d VALUE", i), 32'(VALUE), 32'(vecs[i].exp_value));
        end

        // ERR rises exactly at the fifth edge after the change
        @(negedge CLK);
        DIG = 4'b0100; SEGS = SBAD;
        for (int e = 1; e <= 7; e++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("err_timing edge%0d", e), 32'(ERR), 32'(e == 5));
            chk($sformatf("err_timing valid edge%0d", e), 32'(VALID), 32'h0);
        end
        chk("err_timing VALUE held", 32'(VALUE), 32'h9876);

        // VALID and VALUE update together at the fifth edge after the last digit
        drive(1, 4'b1000, S1, 6, vc, ec);
        drive(1, 4'b0100, S2, 6, vc, ec);
        drive(1, 4'b0010, S3, 6, vc, ec);
        @(negedge CLK);
        DIG = 4'b0001; SEGS = S4;
        for (int e = 1; e <= 7; e++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("valid_timing edge%0d", e), 32'(VALID), 32'(e == 5));
            chk($sformatf("valid_timing VALUE edge%0d", e), 32'(VALUE),
                (e < 5) ? 32'h9876 : 32'h1234);
        end

        // reset mid-frame discards the partial frame
        drive(1, 4'b1000, S9, 6, vc, ec);
        drive(1, 4'b0100, S8, 6, vc, ec);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("midreset VALUE", 32'(VALUE), 32'h0);
        chk("midreset VALID", 32'(VALID), 32'h0);
        chk("midreset ERR",   32'(ERR),   32'h0);
        @(negedge CLK);
        RST = 1'b0;
        drive(1, 4'b0010, S7, 6, vc, ec);
        chk("post_reset d1 valid", 32'(vc), 32'h0);
        drive(1, 4'b0001, S6, 6, vc, ec);
        chk("post_reset d0 valid", 32'(vc), 32'h0);
        chk("post_reset VALUE", 32'(VALUE), 32'h0);
        drive(1, 4'b1000, S9, 6, vc, ec);
        drive(1, 4'b0100, S8, 6, vc, ec);
        chk("post_reset frame valid", 32'(vc), 32'h1);
        chk("post_reset frame err", 32'(ec), 32'h0);
        chk("post_reset frame VALUE", 32'(VALUE), 32'h9876);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side companion to the seven-segment decoder.
- Monitors a 4-digit multiplexed seven-segment display bus (one-hot digit strobes plus segment lines).
- Decodes each stable segment pattern back to BCD and assembles a 16-bit BCD value once all four digits of a scan frame are captured.
- Used in self-checking benches and in board loopback to read back what the display is showing.

Parameters:
- STABLE_CYC, 4, number of consecutive identical samples (DIG, SEGS) required before a digit is accepted; legal range 2..255.
- CNT_W, 8, run-length counter width; must hold STABLE_CYC.

Ports:
- CLK    input   1   rising-edge clock.
- RST    input   1   synchronous, active-high reset.
- EN     input   1   capture enable; low clears the frame in progress.
- DIG    input   4   digit strobes, active high, one-hot; DIG[0] = least-significant digit; 0000 = blanking.
- SEGS   input   7   segment lines, active high; SEGS[6]=a ... SEGS[0]=g.
- VALUE  output  16  last complete frame, BCD; VALUE[3:0] = digit 0.
- VALID  output  1   one-cycle pulse when VALUE is updated.
- ERR    output  1   one-cycle pulse on an illegal accepted sample.

Behaviour:
- Reset (RST=1 at an edge): VALUE=0, VALID=0, ERR=0, got mask=0000, shadow nibbles=0, run counter=0, sample register=0, taken flag=0.
- Input stage: {DIG,SEGS} registered every cycle into the sample register (1 cycle latency).
- Run counter:
  - New registered sample equal to previous: increment, saturating at STABLE_CYC.
  - Otherwise: reset to 1 and clear taken.
- Accept: counter reaches STABLE_CYC and taken=0 -> one accept, set taken. A held pattern is accepted exactly once per dwell.
- Decode table (SEGS -> BCD):
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4
  - 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9
  - Anything else is illegal.
- On accept:
  - DIG=0000: ignored, no state change.
  - DIG one-hot and SEGS legal: shadow[idx] <= BCD, got[idx] <= 1. Re-capturing an already-captured digit overwrites it, no error.
  - DIG not one-hot, or SEGS illegal with DIG non-zero: ERR=1 for one cycle, got <= 0000, shadow retained.
- Frame complete: an accept makes got = 1111 (including the digit just accepted) ->
  - On the same edge: VALUE <= shadow merged with the new digit, VALID=1 for one cycle, got <= 0000.
- Latency: VALID/ERR rise at edge STABLE_CYC+1 after the final input change (1 input reg + STABLE_CYC dwell edges).
- EN=0:
  - got <= 0000, run counter <= 0, taken <= 0.
  - No accepts; VALID=ERR=0.
  - VALUE holds.
  - Re-enable starts a fresh dwell: first accept at STABLE_CYC edges after EN=1.
- RST has priority over EN and every other event; reset mid-frame discards the partial frame.
- Simultaneous frame completion and ERR cannot occur; an erroneous accept never sets got.
- Glitches shorter than STABLE_CYC samples are never accepted and never raise ERR.
- Outputs are fully registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then EN=1 and drive digits 3,2,1,0 (DIG 1000/0100/0010/0001) with patterns 1111001/1101101/0110000/1111110, each held 6 cycles -> exactly one VALID pulse, VALUE=16'h3210, ERR never high.
- Hold DIG=0001, SEGS=1011011 for 20 cycles after a complete frame -> got[0] set once; no extra VALID, no ERR.
- Illegal pattern SEGS=0000001 on DIG=0010 held 5 cycles, mid-frame -> one ERR pulse at edge 5 after the change; previous VALUE unchanged; four further legal digits then yield VALID.
- DIG=0110 (two strobes) with SEGS=1111111 held 5 cycles -> ERR pulse; got cleared.
- 3-cycle glitch SEGS=1111111 on DIG=0001 between legal digits (STABLE_CYC=4) -> ignored, no ERR, frame value unaffected.
- Assert EN=0 after three digits, re-enable, send all four digits 9,8,7,6 -> single VALID with VALUE=16'h9876. Separately, assert RST mid-frame -> VALUE=0, VALID=0, ERR=0 the next cycle.
